// File: rtl/fir_out_fifo.sv
// Output buffer between the FIR result stream and the downstream AXI-Stream sink.
// Optional statistics counters are enabled with `define FIR_OUT_FIFO_STATS_EN.
module fir_out_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 8
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tlast,
    input  logic [pDATA_WIDTH-1:0]   s_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_done,
    input  logic                     stat_clr,
    output logic [31:0]              sample_cnt,
    output logic [15:0]              frame_cnt
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);

    logic [pDATA_WIDTH:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_level;
    logic                 r_frame_done;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;

    assign w_full   = (r_level == FULL_LVL);
    assign w_empty  = (r_level == {(AW+1){1'b0}});
    // Ready is held low during reset so no beat is taken while state is clearing.
    assign s_tready = axis_rst_n & ~w_full;
    assign m_tvalid = ~w_empty;
    assign w_push   = s_tvalid & s_tready;
    assign w_pop    = m_tvalid & m_tready;

    assign m_tdata    = r_mem[r_rd_ptr][pDATA_WIDTH-1:0];
    assign m_tlast    = r_mem[r_rd_ptr][pDATA_WIDTH];
    assign level      = r_level;
    assign frame_done = r_frame_done;

    // Sample storage; contents survive reset because the pointers define validity.
    always_ff @(posedge axis_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    // Pointers, occupancy and end-of-frame pulse.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_wr_ptr     <= {AW{1'b0}};
            r_rd_ptr     <= {AW{1'b0}};
            r_level      <= {(AW+1){1'b0}};
            r_frame_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            r_frame_done <= w_pop & m_tlast;
        end
    end

`ifdef FIR_OUT_FIFO_STATS_EN
    logic [31:0] r_sample_cnt;
    logic [15:0] r_frame_cnt;

    // Statistics counters; a clear wins over a same-cycle increment.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_sample_cnt <= 32'd0;
            r_frame_cnt  <= 16'd0;
        end else if (stat_clr) begin
            r_sample_cnt <= 32'd0;
            r_frame_cnt  <= 16'd0;
        end else begin
            if (w_push) begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end
            if (w_pop && m_tlast) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign sample_cnt = r_sample_cnt;
    assign frame_cnt  = r_frame_cnt;
`else
    logic w_unused_stat_clr;

    assign w_unused_stat_clr = stat_clr;
    assign sample_cnt        = 32'd0;
    assign frame_cnt         = 16'd0;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed bench for fir_out_fifo: reset, single beat, fill/full, framing, reset mid-stream, wrap.
module tb_fir_out_fifo;

`ifdef FIR_OUT_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  level;
    logic        frame_done;
    logic        stat_clr;
    logic [31:0] sample_cnt;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    fir_out_fifo #(.pDATA_WIDTH(32), .DEPTH(8)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .s_tdata    (s_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .level      (level),
        .frame_done (frame_done),
        .stat_clr   (stat_clr),
        .sample_cnt (sample_cnt),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Concurrent producer/consumer with a bench-side occupancy model.
    task automatic run_stream(input int n, input int last_idx, input logic [15:0] rpat,
                              input logic [15:0] vpat, input logic [31:0] base);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int lvl = 0;
        int fd_cnt = 0;
        logic exp_fd;
        logic push;
        logic pop;
        while ((got < n) && (cyc < 400)) begin
            s_tvalid = (sent < n) && vpat[cyc % 16];
            s_tdata  = base + 32'(sent);
            s_tlast  = ((sent + 1) == last_idx);
            m_tready = rpat[cyc % 16];
            chk("str_s_tready", 32'(s_tready), 32'(lvl != 8));
            chk("str_m_tvalid", 32'(m_tvalid), 32'(lvl != 0));
            push   = s_tvalid && (lvl != 8);
            pop    = m_tready && (lvl != 0);
            exp_fd = 1'b0;
            if (pop) begin
                chk("str_data", m_tdata, base + 32'(got));
                chk("str_last", 32'(m_tlast), 32'((got + 1) == last_idx));
                exp_fd = ((got + 1) == last_idx);
                got++;
            end
            if (push) sent++;
            lvl = lvl + int'(push) - int'(pop);
            tick();
            chk("str_fdone", 32'(frame_done), 32'(exp_fd));
            chk("str_level", 32'(level), 32'(lvl));
            if (frame_done) fd_cnt++;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        chk("str_count", 32'(got), 32'(n));
        chk("str_fd_pulses", 32'(fd_cnt), 32'(last_idx != 0));
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 32'd0;
        m_tready = 1'b0;
        stat_clr = 1'b0;
        tick();
        tick();
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_scnt", sample_cnt, 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_s_tready", 32'(s_tready), 32'd1);

        // Single beat with the sink ready
        s_tvalid = 1'b1;
        s_tdata  = 32'h0000_1234;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        chk("sb_no_bypass", 32'(m_tvalid), 32'd0);
        tick();
        s_tvalid = 1'b0;
        chk("sb_valid", 32'(m_tvalid), 32'd1);
        chk("sb_data", m_tdata, 32'h0000_1234);
        chk("sb_level1", 32'(level), 32'd1);
        tick();
        chk("sb_level0", 32'(level), 32'd0);
        chk("sb_empty", 32'(m_tvalid), 32'd0);

        // Fill to full with the sink stalled
        m_tready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(i);
            tick();
            chk("fill_level", 32'(level), 32'(i));
        end
        chk("full_s_tready", 32'(s_tready), 32'd0);
        s_tdata = 32'd9;
        tick();
        chk("full_no_push", 32'(level), 32'd8);
        chk("full_hold_data", m_tdata, 32'd1);

        // Full with a concurrent pop: only the pop happens
        s_tdata  = 32'h99;
        m_tready = 1'b1;
        tick();
        chk("fp_level", 32'(level), 32'd7);
        chk("fp_data", m_tdata, 32'd2);
        chk("fp_ready", 32'(s_tready), 32'd1);
        tick();
        s_tvalid = 1'b0;
        chk("fp_both_level", 32'(level), 32'd7);
        for (int i = 3; i <= 9; i++) begin
            chk("drain_valid", 32'(m_tvalid), 32'd1);
            chk("drain_data", m_tdata, (i == 9) ? 32'h99 : 32'(i));
            tick();
        end
        chk("drain_empty", 32'(level), 32'd0);

        // Clear concurrent with a push wins
        stat_clr = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'h55;
        m_tready = 1'b0;
        tick();
        stat_clr = 1'b0;
        s_tvalid = 1'b0;
        chk("clr_scnt", sample_cnt, 32'd0);
        chk("clr_fcnt", 32'(frame_cnt), 32'd0);
        chk("clr_data", m_tdata, 32'h55);
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        chk("clr_drain", 32'(level), 32'd0);

        // 11-sample frame with irregular sink stalls
        run_stream(11, 11, 16'b1011_0010_1110_0101, 16'hFFFF, 32'h100);
        chk("frm_fcnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
        chk("frm_scnt", sample_cnt, STATS ? 32'd11 : 32'd0);

        // Reset with five entries stored
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h200 + 32'(i);
            tick();
        end
        s_tvalid = 1'b0;
        chk("mid_level5", 32'(level), 32'd5);
        rst_n = 1'b0;
        tick();
        tick();
        chk("mid_level0", 32'(level), 32'd0);
        chk("mid_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_s_tready", 32'(s_tready), 32'd0);
        chk("mid_scnt", sample_cnt, 32'd0);
        chk("mid_fcnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        s_tvalid = 1'b1;
        s_tdata  = 32'h3C3C;
        s_tlast  = 1'b1;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("post_level", 32'(level), 32'd1);
        chk("post_data", m_tdata, 32'h3C3C);
        chk("post_last", 32'(m_tlast), 32'd1);
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        chk("post_fdone", 32'(frame_done), 32'd1);
        chk("post_fcnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);
        tick();
        chk("post_fdone_low", 32'(frame_done), 32'd0);

        // 20 beats across pointer wrap, alternating stall shapes
        run_stream(20, 0, 16'b0000_1111_0101_0011, 16'b1111_0110_1111_1101, 32'hA000);
        chk("wrap_scnt", sample_cnt, STATS ? 32'd21 : 32'd0);
        chk("wrap_fcnt", 32'(frame_cnt), STATS ? 32'd1 : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_out_fifo.md
FIR_OUT_FIFO -- requirements
Module: fir_out_fifo

Interface
REQ-001 The block SHALL have parameter pDATA_WIDTH, default 32, sample width.
REQ-002 The block SHALL have parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-003 The block SHALL have port axis_clk, input, 1, clock; all logic on its rising edge.
REQ-004 The block SHALL have port axis_rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port s_tvalid / s_tready / s_tlast, input / output / input, 1 each, upstream AXI-Stream handshake fed by the FIR sm_t* outputs.
REQ-006 The block SHALL have port s_tdata, input, pDATA_WIDTH, FIR result sample.
REQ-007 The block SHALL have port m_tvalid / m_tready / m_tlast, output / input / output, 1 each, downstream AXI-Stream handshake.
REQ-008 The block SHALL have port m_tdata, output, pDATA_WIDTH, buffered sample.
REQ-009 The block SHALL have port level, output, log2(DEPTH)+1, current occupancy.
REQ-010 The block SHALL have port frame_done, output, 1, one-cycle pulse when a tlast beat leaves the FIFO.
REQ-011 The block SHALL have port stat_clr, input, 1, synchronous clear of statistics counters.
REQ-012 The block SHALL have port sample_cnt, output, 32, accepted-sample count.
REQ-013 The block SHALL have port frame_cnt, output, 16, completed-frame count.

Function
REQ-014 The block SHALL store {s_tlast, s_tdata} per entry in a circular buffer with separate write and read pointers of log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-015 Push SHALL occur when s_tvalid && s_tready; pop SHALL occur when m_tvalid && m_tready.
REQ-016 s_tready SHALL equal (level != DEPTH); a push SHALL NOT be accepted when full, even if a pop occurs in the same cycle.
REQ-017 m_tvalid SHALL equal (level != 0); m_tdata/m_tlast SHALL present the entry at the read pointer (first-word fall-through).
REQ-018 Latency from push edge to m_tvalid high SHALL be exactly one cycle; no combinational s_* to m_* bypass.
REQ-019 Simultaneous push and pop SHALL leave level unchanged and advance both pointers.
REQ-020 Once asserted, m_tvalid, m_tdata and m_tlast SHALL hold stable until popped.
REQ-021 frame_done SHALL pulse high for one cycle in the cycle after a pop with m_tlast=1.
REQ-022 level SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.

Reset
REQ-023 On axis_rst_n low, pointers and level SHALL clear to 0; m_tvalid=0, s_tready=1 (after reset release), frame_done=0, sample_cnt=0, frame_cnt=0.
REQ-024 Reset mid-frame SHALL discard all stored entries; buffer contents need not be cleared.
REQ-025 s_tready SHALL be 0 while axis_rst_n is low.

Configuration
REQ-026 Macro FIR_OUT_FIFO_STATS_EN SHALL control the statistics counters.
REQ-027 With FIR_OUT_FIFO_STATS_EN defined: sample_cnt SHALL increment per push, and frame_cnt SHALL increment per pop with m_tlast=1; both wrap at maximum; stat_clr SHALL zero both and take priority over a same-cycle increment.
REQ-028 Without FIR_OUT_FIFO_STATS_EN: sample_cnt and frame_cnt SHALL be constant 0, stat_clr SHALL be ignored, and ports SHALL remain present.

Verification
REQ-029 Single beat: push 0x0000_1234 with tlast=0 while m_tready=1 -> m_tvalid one cycle later with 0x1234, then level back to 0.
REQ-030 Fill: m_tready=0, push 8 beats 1..8 -> level=8, s_tready=0; 9th s_tvalid is not accepted; raise m_tready -> outputs 1..8 in order.
REQ-031 Full with concurrent pop: level=8, s_tvalid=1, m_tready=1 -> one pop, no push that cycle; push accepted the next cycle.
REQ-032 Frame: 11-sample frame with tlast on sample 11, random m_tready stalls -> m_tlast only on the 11th output, frame_done one pulse, frame_cnt=1, sample_cnt=11 (stats enabled).
REQ-033 Reset mid-stream: level=5, assert axis_rst_n low for 2 cycles -> level=0, m_tvalid=0, counters 0; a new push after release outputs correctly.
REQ-034 Wrap: stream 20 beats with alternating stall patterns -> no loss or duplication across pointer wrap; with macro undefined, sample_cnt stays 0.
